// File: rtl/bj_pkg.sv
// Shared blackjack definitions: FSM state encodings, default card/shoe sizes
// and card value encoding.
package bj_pkg;

    localparam int BJ_CARD_W    = 4;
    localparam int BJ_DECK_SIZE = 52;

    // Arbiter FSM state encodings
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    // Card value encoding (1..13)
    localparam logic [3:0] CARD_ACE   = 4'd1;
    localparam logic [3:0] CARD_TEN   = 4'd10;
    localparam logic [3:0] CARD_JACK  = 4'd11;
    localparam logic [3:0] CARD_QUEEN = 4'd12;
    localparam logic [3:0] CARD_KING  = 4'd13;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: searches req_i upward from ptr_i with wrap,
// returns a one-hot grant (all zero when nothing is requesting).
module rr_arbiter #(
    parameter int N_REQ = 2,
    parameter int PTR_W = 1
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N_REQ-1:0] gnt_o
);

    int   idx;
    logic found;

    // First requester at or above the pointer wins, wrapping past N_REQ-1
    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = int'(ptr_i) + i;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/card_req_arbiter.sv
// Shares the random-card generator between N_REQ requesters with round-robin
// grant, one outstanding card request at a time, and tracks cards left in the
// shoe. Optional feature macro CARD_TIMEOUT_EN adds a generator response
// timeout and the timeout_o port.
//
// Handshake: req_i is a level held by the requester until its ack_o pulse;
// gnt_o marks the owner from REQ through RESP; req_card_o is a single-cycle
// request to the generator, answered by a single-cycle card_valid_i strobe
// that is only honoured while waiting for it.
module card_req_arbiter
    import bj_pkg::*;
#(
    parameter int N_REQ       = 2,
    parameter int CARD_W      = BJ_CARD_W,
    parameter int DECK_SIZE   = BJ_DECK_SIZE,
    parameter int CNT_W       = 6,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              clk_arb_i,
    input  logic              rst_arb_i,
    input  logic [N_REQ-1:0]  req_i,
    input  logic              reshuffle_i,
    input  logic              card_valid_i,
    input  logic [CARD_W-1:0] card_val_i,
    output logic              req_card_o,
    output logic [N_REQ-1:0]  gnt_o,
    output logic [N_REQ-1:0]  ack_o,
    output logic [CARD_W-1:0] card_o,
    output logic [CNT_W-1:0]  cards_left_o,
    output logic              deck_empty_o,
`ifdef CARD_TIMEOUT_EN
    output logic              timeout_o,
`endif
    output logic              busy_o
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [CNT_W-1:0] FULL_SHOE = CNT_W'(DECK_SIZE);

    logic [1:0]        state_q, state_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [CARD_W-1:0] card_q, card_d;
    logic [CNT_W-1:0]  left_q, left_d;
    logic              shuf_pend_q, shuf_pend_d;

    logic [N_REQ-1:0]  rr_gnt;
    logic [PTR_W-1:0]  gnt_idx;
    logic [PTR_W-1:0]  ptr_after_gnt;

`ifdef CARD_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             timeout_q, timeout_d;
`endif

    rr_arbiter #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr (
        .req_i (req_i),
        .ptr_i (ptr_q),
        .gnt_o (rr_gnt)
    );

    // One-hot owner to index, then the pointer value that demotes the owner
    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_q[i]) begin
                gnt_idx = PTR_W'(i);
            end
        end
        ptr_after_gnt = (gnt_idx == PTR_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end

    // Next-state logic: FSM, shoe counter, pending reshuffle, RR pointer
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        ptr_d       = ptr_q;
        card_d      = card_q;
        left_d      = left_q;
        shuf_pend_d = shuf_pend_q;
`ifdef CARD_TIMEOUT_EN
        tmo_cnt_d   = tmo_cnt_q;
        timeout_d   = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                // A reshuffle (fresh or deferred) takes the whole IDLE cycle
                if (reshuffle_i || shuf_pend_q) begin
                    left_d      = FULL_SHOE;
                    shuf_pend_d = 1'b0;
                end else if ((|req_i) && (left_q != '0)) begin
                    gnt_d   = rr_gnt;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                state_d = ST_WAIT;
`ifdef CARD_TIMEOUT_EN
                tmo_cnt_d = '0;
`endif
            end
            ST_WAIT: begin
                if (card_valid_i) begin
                    card_d  = card_val_i;
                    if (left_q != '0) begin
                        left_d = left_q - 1'b1;
                    end
                    state_d = ST_RESP;
                end
`ifdef CARD_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_LAST) begin
                    timeout_d = 1'b1;
                    ptr_d     = ptr_after_gnt;
                    gnt_d     = '0;
                    state_d   = ST_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
`endif
            end
            default: begin
                ptr_d   = ptr_after_gnt;
                gnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
        // Reshuffle requests arriving mid-transaction are deferred to IDLE
        if ((state_q != ST_IDLE) && reshuffle_i) begin
            shuf_pend_d = 1'b1;
        end
    end

    // State registers; reset discards any in-flight card
    always_ff @(posedge clk_arb_i or negedge rst_arb_i) begin
        if (!rst_arb_i) begin
            state_q     <= ST_IDLE;
            gnt_q       <= '0;
            ptr_q       <= '0;
            card_q      <= '0;
            left_q      <= FULL_SHOE;
            shuf_pend_q <= 1'b0;
`ifdef CARD_TIMEOUT_EN
            tmo_cnt_q   <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            ptr_q       <= ptr_d;
            card_q      <= card_d;
            left_q      <= left_d;
            shuf_pend_q <= shuf_pend_d;
`ifdef CARD_TIMEOUT_EN
            tmo_cnt_q   <= tmo_cnt_d;
            timeout_q   <= timeout_d;
`endif
        end
    end

    // Outputs decoded from registered state
    always_comb begin
        req_card_o   = (state_q == ST_REQ);
        gnt_o        = gnt_q;
        ack_o        = (state_q == ST_RESP) ? gnt_q : '0;
        card_o       = card_q;
        cards_left_o = left_q;
        deck_empty_o = (left_q == '0);
        busy_o       = (state_q != ST_IDLE);
`ifdef CARD_TIMEOUT_EN
        timeout_o    = timeout_q;
`endif
    end

endmodule

// File: tb/tb_card_req_arbiter.sv
// Self-checking bench for card_req_arbiter: transaction-level model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_card_req_arbiter;

  localparam int N_REQ       = 2;
  localparam int CARD_W      = 4;
  localparam int DECK_SIZE   = 52;
  localparam int CNT_W       = 6;
  localparam int TIMEOUT_CYC = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N_REQ-1:0]  req;
  logic              reshuffle;
  logic              card_valid;
  logic [CARD_W-1:0] card_val;
  logic              req_card;
  logic [N_REQ-1:0]  gnt;
  logic [N_REQ-1:0]  ack;
  logic [CARD_W-1:0] card;
  logic [CNT_W-1:0]  cards_left;
  logic              deck_empty;
  logic              busy;
`ifdef CARD_TIMEOUT_EN
  logic              timeout;
`endif

  card_req_arbiter #(
    .N_REQ(N_REQ), .CARD_W(CARD_W), .DECK_SIZE(DECK_SIZE),
    .CNT_W(CNT_W), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk_arb_i    (clk),
    .rst_arb_i    (rst_n),
    .req_i        (req),
    .reshuffle_i  (reshuffle),
    .card_valid_i (card_valid),
    .card_val_i   (card_val),
    .req_card_o   (req_card),
    .gnt_o        (gnt),
    .ack_o        (ack),
    .card_o       (card),
    .cards_left_o (cards_left),
    .deck_empty_o (deck_empty),
`ifdef CARD_TIMEOUT_EN
    .timeout_o    (timeout),
`endif
    .busy_o       (busy)
  );

  int checks = 0;
  int errors = 0;
  int reqc_cnt = 0;
  logic [CARD_W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A transaction: owner chosen, request issued, card received, then delivered.
  int         m_owner;
  bit         m_issued, m_have, m_pend, m_tmo;
  int         m_ptr, m_left, m_age;
  logic [3:0] m_card;

  task automatic m_reset();
    m_owner = -1; m_issued = 0; m_have = 0; m_pend = 0; m_tmo = 0;
    m_ptr = 0; m_left = DECK_SIZE; m_age = 0; m_card = '0;
  endtask

  function automatic int m_pick(input logic [N_REQ-1:0] r);
    for (int k = 0; k < N_REQ; k++) begin
      if (r[(m_ptr + k) % N_REQ]) return (m_ptr + k) % N_REQ;
    end
    return -1;
  endfunction

  task automatic m_step(input logic [N_REQ-1:0] r, input logic sh, input logic cv,
                        input logic [3:0] cval);
    m_tmo = 0;
    if (m_owner < 0) begin
      if (sh || m_pend) begin
        m_left = DECK_SIZE;
        m_pend = 0;
      end else if (r != '0 && m_left > 0) begin
        m_owner = m_pick(r);
        m_issued = 0;
        m_have = 0;
      end
    end else begin
      if (sh) m_pend = 1;
      if (!m_issued) begin
        m_issued = 1;
        m_age = 0;
      end else if (!m_have) begin
        if (cv) begin
          m_have = 1;
          m_card = cval;
          m_left = m_left - 1;
        end
`ifdef CARD_TIMEOUT_EN
        else if (m_age == TIMEOUT_CYC - 1) begin
          m_tmo = 1;
          m_ptr = (m_owner + 1) % N_REQ;
          m_owner = -1;
        end else begin
          m_age++;
        end
`endif
      end else begin
        m_ptr = (m_owner + 1) % N_REQ;
        m_owner = -1;
      end
    end
  endtask

  // ---------------- compare process ----------------
  initial begin
    logic [N_REQ-1:0] e_gnt;
    logic [CARD_W-1:0] e_card;
    m_reset();
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_reset();
        exp_q.delete();
      end else begin
        m_step(req, reshuffle, card_valid, card_val);
      end
      #1;
      e_gnt = (m_owner >= 0) ? N_REQ'(1 << m_owner) : '0;
      chk("gnt_o", 32'(gnt), 32'(e_gnt));
      chk("ack_o", 32'(ack), m_have ? 32'(e_gnt) : 32'd0);
      chk("req_card_o", 32'(req_card), 32'(m_owner >= 0 && !m_issued));
      chk("busy_o", 32'(busy), 32'(m_owner >= 0));
      chk("cards_left_o", 32'(cards_left), 32'(m_left));
      chk("deck_empty_o", 32'(deck_empty), 32'(m_left == 0));
      chk("card_o", 32'(card), 32'(m_card));
`ifdef CARD_TIMEOUT_EN
      chk("timeout_o", 32'(timeout), 32'(m_tmo));
`endif
      if (req_card) reqc_cnt++;
      if (|ack) begin
        if (exp_q.size() == 0) begin
          chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
          e_card = exp_q.pop_front();
          chk("delivered_card", 32'(card), 32'(e_card));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req = '0; reshuffle = 1'b0; card_valid = 1'b0; card_val = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_reqc();
    for (int i = 0; i < 60; i++) begin
      if (req_card) return;
      @(negedge clk);
    end
    chk("req_card_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_ack(output logic [N_REQ-1:0] a);
    a = '0;
    for (int i = 0; i < 60; i++) begin
      if (|ack) begin
        a = ack;
        return;
      end
      @(negedge clk);
    end
    chk("ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic gen_reply(input int d, input logic [CARD_W-1:0] v);
    wait_reqc();
    repeat (d) @(negedge clk);
    card_valid = 1'b1;
    card_val = v;
    exp_q.push_back(v);
    @(negedge clk);
    card_valid = 1'b0;
  endtask

  task automatic draw(input logic [N_REQ-1:0] r, input logic [CARD_W-1:0] v,
                      output logic [N_REQ-1:0] a);
    req = r;
    gen_reply(1, v);
    wait_ack(a);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    logic [N_REQ-1:0] a;
    logic [N_REQ-1:0] order[$];
    int rc0;
    req = '0; reshuffle = 1'b0; card_valid = 1'b0; card_val = '0;
    repeat (3) @(negedge clk);
    chk("rst_cards_left", 32'(cards_left), 32'd52);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_empty", 32'(deck_empty), 32'd0);
    rst_n = 1'b1;

    // Single request, reply two cycles after req_card_o
    @(negedge clk);
    rc0 = reqc_cnt;
    req = 2'b01;
    gen_reply(2, 4'd7);
    wait_ack(a);
    req = '0;
    chk("t1_ack", 32'(a), 32'b01);
    chk("t1_card", 32'(card), 32'd7);
    chk("t1_left", 32'(cards_left), 32'd51);
    chk("t1_reqc_pulses", 32'(reqc_cnt - rc0), 32'd1);

    // Both requesting: alternation from a fresh pointer
    do_reset();
    for (int i = 0; i < 4; i++) begin
      draw(2'b11, 4'(2 + i), a);
      order.push_back(a);
    end
    req = '0;
    chk("t2_ack0", 32'(order[0]), 32'b01);
    chk("t2_ack1", 32'(order[1]), 32'b10);
    chk("t2_ack2", 32'(order[2]), 32'b01);
    chk("t2_ack3", 32'(order[3]), 32'b10);
    chk("t2_left", 32'(cards_left), 32'd48);

    // Drain the shoe, then a pending request waits for reshuffle
    do_reset();
    for (int i = 0; i < 52; i++) draw(2'b01, 4'(1 + (i % 13)), a);
    rc0 = reqc_cnt;
    repeat (10) @(negedge clk);
    chk("t3_no_reqc", 32'(reqc_cnt - rc0), 32'd0);
    chk("t3_empty", 32'(deck_empty), 32'd1);
    chk("t3_left0", 32'(cards_left), 32'd0);
    chk("t3_idle", 32'(busy), 32'd0);
    reshuffle = 1'b1;
    @(negedge clk);
    reshuffle = 1'b0;
    chk("t3_reload", 32'(cards_left), 32'd52);
    chk("t3_no_gnt_same_cycle", 32'(busy), 32'd0);
    @(negedge clk);
    chk("t3_gnt", 32'(gnt), 32'b01);
    chk("t3_reqc", 32'(req_card), 32'd1);
    gen_reply(1, 4'd9);
    wait_ack(a);
    req = '0;
    chk("t3_card", 32'(card), 32'd9);
    chk("t3_left51", 32'(cards_left), 32'd51);

    // Reshuffle during WAIT with 10 cards left is deferred past RESP
    for (int i = 0; i < 41; i++) draw(2'b10, 4'd13, a);
    chk("t4_left10", 32'(cards_left), 32'd10);
    req = 2'b01;
    wait_reqc();
    @(negedge clk);
    reshuffle = 1'b1;
    @(negedge clk);
    reshuffle = 1'b0;
    card_valid = 1'b1;
    card_val = 4'd5;
    exp_q.push_back(4'd5);
    @(negedge clk);
    card_valid = 1'b0;
    wait_ack(a);
    req = '0;
    chk("t4_ack", 32'(a), 32'b01);
    chk("t4_left9_in_resp", 32'(cards_left), 32'd9);
    repeat (2) @(negedge clk);
    chk("t4_left_reloaded", 32'(cards_left), 32'd52);

    // Stray card_valid in IDLE is ignored
    card_valid = 1'b1;
    card_val = 4'd12;
    @(negedge clk);
    card_valid = 1'b0;
    @(negedge clk);
    chk("t5_card_kept", 32'(card), 32'd5);
    chk("t5_left_kept", 32'(cards_left), 32'd52);

    // Reset asserted in WAIT
    draw(2'b10, 4'd3, a);
    req = '0;
    @(negedge clk);
    chk("t6_left51", 32'(cards_left), 32'd51);
    req = 2'b01;
    wait_reqc();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    req = '0;
    #1;
    chk("t6_left", 32'(cards_left), 32'd52);
    chk("t6_gnt", 32'(gnt), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_card", 32'(card), 32'd0);
    chk("t6_reqc", 32'(req_card), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

`ifdef CARD_TIMEOUT_EN
    // No generator response: timeout, no ack, pointer moves past owner
    begin
      bit seen;
      seen = 0;
      do_reset();
      req = 2'b11;
      wait_reqc();
      chk("t7_first_gnt", 32'(gnt), 32'b01);
      for (int i = 0; i < 40 && !seen; i++) begin
        @(negedge clk);
        if (timeout) seen = 1;
      end
      chk("t7_timeout_seen", 32'(seen), 32'd1);
      chk("t7_left", 32'(cards_left), 32'd52);
      wait_reqc();
      chk("t7_next_gnt", 32'(gnt), 32'b10);
      gen_reply(1, 4'd4);
      wait_ack(a);
      req = '0;
      chk("t7_ack", 32'(a), 32'b10);
    end
`endif

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
